// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control sequencer for the Aeolus 4-bit datapath.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a step input that gates leaving FETCH.
module cpu_sequencer #(
    parameter logic [3:0] PC_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [7:0] instr,
    input  logic       zero,
    input  logic       carry,
    output logic [3:0] pc,
    output logic [3:0] imm,
    output logic [1:0] alu_op,
    output logic       acc_en,
    output logic       flag_en,
    output logic       out_en,
    output logic       halted
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] op;
    logic       go;
    logic       exec;
    logic       taken;

    assign op = ir_q[7:4];
`ifdef SEQ_SINGLE_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    // Next state, IR load in FETCH, pc update in EXECUTE (HLT keeps pc)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        taken   = op == 4'h4 || (op == 4'h5 && zero) || (op == 4'h6 && carry);
        case (state_q)
            FETCH: begin
                ir_d    = instr;
                state_d = go ? DECODE : FETCH;
            end
            DECODE:  state_d = EXECUTE;
            EXECUTE: begin
                state_d = op == 4'h8 ? HALT : FETCH;
                pc_d    = taken ? ir_q[3:0] : op == 4'h8 ? pc_q : pc_q + 4'd1;
            end
            default: state_d = HALT;
        endcase
    end

    // Sequencer state, program counter and instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Datapath controls decoded from state and IR; enables only in EXECUTE
    always_comb begin
        exec    = state_q == EXECUTE;
        pc      = pc_q;
        imm     = ir_q[3:0];
        alu_op  = (state_q == DECODE || exec) ? (op == 4'h2 ? 2'b01 : op == 4'h3 ? 2'b10 : 2'b00) : 2'b00;
        acc_en  = exec && op inside {4'h1, 4'h2, 4'h3};
        flag_en = exec && op inside {4'h1, 4'h2, 4'h3};
        out_en  = exec && op == 4'h7;
        halted  = state_q == HALT;
    end
endmodule
